// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
//   Shared definitions for the cost display path: display geometry, the
//   7-segment encodings ({g,f,e,d,c,b,a}, active-high), the blank code and the
//   state type of the sequential binary-to-BCD converter.
// -----------------------------------------------------------------------------
package parking_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_e;

  // Non-decimal nibbles cannot come out of the converter; they map to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) seg = SEG_LUT[i];
    end
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential shift-add-3 (double-dabble) converter. A strobe in IDLE starts a
//   conversion of exactly VAL_W shift cycles followed by one DONE cycle that
//   publishes the result. Strobes arriving while a conversion is running
//   (including the DONE cycle) are parked in a one-deep pending register, the
//   latest one winning, and converted right after the current one.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   value_in     in   [VAL_W-1:0] binary value
//   value_valid  in   one-cycle load strobe
//   busy         out  conversion in progress (CONVERT or DONE)
//   bcd_out      out  [15:0] held result {thousands,hundreds,tens,ones}
//   bcd_valid    out  one-cycle pulse in the cycle bcd_out takes a new value
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import parking_pkg::*;
#(
  parameter int VAL_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] value_in,
  input  logic             value_valid,
  output logic             busy,
  output logic [15:0]      bcd_out,
  output logic             bcd_valid
);

  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  conv_state_e      state_q, state_d;
  logic [VAL_W-1:0] operand_q, operand_d;
  logic [BCD_W-1:0] scratch_q, scratch_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [VAL_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic [BCD_W-1:0] adjusted;

  // Add-3 correction: any digit >= 5 would exceed 9 after doubling.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    operand_d  = operand_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    bcd_d      = bcd_q;
    valid_d    = 1'b0;

    // A strobe outside IDLE is parked; a newer one overwrites an older one.
    if (value_valid && (state_q != IDLE)) begin
      pend_val_d = value_in;
      pend_d     = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A fresh strobe supersedes anything still pending.
        if (value_valid || pend_q) begin
          operand_d = value_valid ? value_in : pend_val_q;
          pend_d    = 1'b0;
          scratch_d = '0;
          count_d   = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = {adjusted[BCD_W-2:0], operand_q[VAL_W-1]};
        operand_d = operand_q << 1;
        count_d   = count_q + 1'b1;
        if (count_q == CNT_W'(VAL_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset release is expected to be synchronous to clk (synchronised upstream).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      operand_q  <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before this edge.
      state_q    <= state_d;
      operand_q  <= operand_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;

  // Four BCD digits cannot hold more than 9999.
  a_value_range : assert property (@(posedge clk) disable iff (!reset)
    value_valid |-> (32'(value_in) <= 32'd9999));

endmodule

// File: rtl/cost_display_scanner.sv
// -----------------------------------------------------------------------------
// cost_display_scanner
//   Converts the parking core's binary cost to BCD (bin2bcd_seq) and scans the
//   held result onto a 4-digit common-anode 7-segment display. The scan
//   free-runs: each digit slot lasts SCAN_DIV clk cycles, ones digit first.
//   an/seg are registered, so the first digit appears one cycle after reset
//   release and an never shows an all-off cycle between slots.
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN  blank leading-zero digits (ones digit always lit);
//                          undefined: all four digits always shown.
//
// Ports
//   clk          in   undivided system clock
//   reset        in   asynchronous active-low reset
//   value_in     in   [VAL_W-1:0] binary cost
//   value_valid  in   one-cycle load strobe
//   busy         out  conversion in progress
//   bcd_out      out  [15:0] held BCD {thousands,hundreds,tens,ones}
//   bcd_valid    out  one-cycle pulse when bcd_out updates
//   seg          out  [6:0] {g,f,e,d,c,b,a}, active-high
//   an           out  [3:0] digit enables, active-low one-hot, an[0] = ones
// -----------------------------------------------------------------------------
module cost_display_scanner
  import parking_pkg::*;
#(
  parameter int VAL_W    = 10,
  parameter int SCAN_DIV = 12500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] value_in,
  input  logic             value_valid,
  output logic             busy,
  output logic [15:0]      bcd_out,
  output logic             bcd_valid,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  logic [15:0]      bcd_held;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       cur_digit;
  logic             blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
`endif

  bin2bcd_seq #(
    .VAL_W(VAL_W)
  ) u_bin2bcd (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .value_valid(value_valid),
    .busy       (busy),
    .bcd_out    (bcd_held),
    .bcd_valid  (bcd_valid)
  );

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 1'b1;  // 2-bit index wraps 3 -> 0 on its own
    end

    cur_digit = bcd_held[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[i]: digit i and every higher digit are zero. Ones never blank.
    lead_zero = '0;
    lead_zero[DIGITS-1] = (bcd_held[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 1; i--) begin
      lead_zero[i] = lead_zero[i+1] && (bcd_held[4*i +: 4] == 4'd0);
    end
    blank = lead_zero[idx_q];
`else
    blank = 1'b0;
`endif

    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= 4'hF;
      seg_q <= SEG_BLANK;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bcd_out = bcd_held;
  assign an      = an_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_cost_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_cost_display_scanner
//   Self-checking bench for cost_display_scanner built with SCAN_DIV = 4.
//   Every strobe that should produce a result pushes its expected BCD onto a
//   scoreboard queue; a negedge monitor pops and compares on each bcd_valid.
// -----------------------------------------------------------------------------
module tb_cost_display_scanner;

  localparam int SD = 4;

  typedef struct {
    logic [9:0]  value;
    logic [15:0] bcd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [9:0]  value_in;
  logic        value_valid;
  logic        busy;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [3:0]  an;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [15:0] sb[$];
  int          valid_cycles[$];
  logic [15:0] exp_bcd;
  vec_t        vecs[14];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h00;
`else
  localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

  cost_display_scanner #(
    .VAL_W   (10),
    .SCAN_DIV(SD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .value_valid(value_valid),
    .busy       (busy),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset && bcd_valid) begin
      valid_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_bcd_valid", 32'(bcd_valid), 32'd0);
      end else begin
        exp_bcd = sb.pop_front();
        check("sb_bcd_out", 32'(bcd_out), 32'(exp_bcd));
      end
    end
  end

  task automatic strobe(input logic [9:0] v, input logic [15:0] exp, input bit push);
    @(negedge clk);
    value_in    = v;
    value_valid = 1'b1;
    if (push) sb.push_back(exp);
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  // Assumes reset was released at the previous negedge.
  task automatic scan_check(input int ncyc);
    logic [3:0] exp_an;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (((c - 1) / SD) % 4));
      check($sformatf("scan_an_c%0d", c), 32'(an), 32'(exp_an));
      check($sformatf("scan_seg_c%0d", c), 32'(seg), 32'((exp_an == 4'hE) ? 7'h3F : LZ_SEG));
    end
  endtask

  // e[k] is the expected segment code while an selects digit k.
  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e[4];
    int         k;
    e = '{e0, e1, e2, e3};
    for (int c = 0; c < 4 * SD; c++) begin
      @(negedge clk);
      k = -1;
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) k = i;
      if (k < 0) check({tag, "_an_onehot"}, 32'(an), 32'hE);
      else check($sformatf("%s_seg_d%0d", tag, k), 32'(seg), 32'(e[k]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{10'd0,    16'h0000}, '{10'd1,   16'h0001}, '{10'd9,   16'h0009},
      '{10'd10,   16'h0010}, '{10'd99,  16'h0099}, '{10'd100, 16'h0100},
      '{10'd512,  16'h0512}, '{10'd999, 16'h0999}, '{10'd1000, 16'h1000},
      '{10'd1023, 16'h1023}, '{10'd42,  16'h0042}, '{10'd255, 16'h0255},
      '{10'd600,  16'h0600}, '{10'd7,   16'h0007}
    };
    value_in    = '0;
    value_valid = 1'b0;
    reset       = 1'b1;

    // Reset values.
    #3 reset = 1'b0;
    #2;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_bcd_out", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bcd_valid", 32'(bcd_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    scan_check(4 * SD + 6);

    // Async reset mid-scan, then a full fresh frame (index wraps 3 -> 0).
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midscan_rst_an", 32'(an), 32'hF);
    check("midscan_rst_seg", 32'(seg), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    scan_check(6 * SD);

    // Latency and busy window for 1023.
    @(negedge clk);
    value_in    = 10'd1023;
    value_valid = 1'b1;
    sb.push_back(16'h1023);
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) value_valid = 1'b0;
      check($sformatf("lat_busy_c%0d", j), 32'(busy), 32'(j >= 1 && j <= 11));
      check($sformatf("lat_valid_c%0d", j), 32'(bcd_valid), 32'(j == 12));
    end
    repeat (2) @(negedge clk);

    // Table of conversions.
    for (int i = 0; i < 14; i++) begin
      strobe(vecs[i].value, vecs[i].bcd, 1'b1);
      repeat (12) @(negedge clk);
      check($sformatf("tbl_hold_%0d", vecs[i].value), 32'(bcd_out), 32'(vecs[i].bcd));
    end

    // Strobes during busy: 255, 600 parked, then 7 parked during 600.
    valid_cycles.delete();
    strobe(10'd255, 16'h0255, 1'b1);
    strobe(10'd600, 16'h0600, 1'b1);
    repeat (12) @(negedge clk);
    strobe(10'd7, 16'h0007, 1'b1);
    repeat (40) @(negedge clk);
    check("busy_seq_count", 32'(valid_cycles.size()), 32'd3);
    if (valid_cycles.size() == 3) begin
      check("busy_seq_gap1", 32'(valid_cycles[1] - valid_cycles[0]), 32'd12);
      check("busy_seq_gap2", 32'(valid_cycles[2] - valid_cycles[1]), 32'd12);
    end
    check("busy_seq_final", 32'(bcd_out), 32'h0007);

    // Strobe landing in the DONE cycle is parked, not lost.
    valid_cycles.delete();
    strobe(10'd5, 16'h0005, 1'b1);
    repeat (9) @(negedge clk);
    check("done_cycle_busy", 32'(busy), 32'd1);
    strobe(10'd8, 16'h0008, 1'b1);
    repeat (30) @(negedge clk);
    check("done_seq_count", 32'(valid_cycles.size()), 32'd2);
    if (valid_cycles.size() == 2)
      check("done_seq_gap", 32'(valid_cycles[1] - valid_cycles[0]), 32'd12);

    // Display frames.
    strobe(10'd1023, 16'h1023, 1'b1);
    repeat (14) @(negedge clk);
    check_frame("f1023", 7'h4F, 7'h5B, 7'h3F, 7'h06);
    strobe(10'd42, 16'h0042, 1'b1);
    repeat (14) @(negedge clk);
    check_frame("f42", 7'h5B, 7'h66, LZ_SEG, LZ_SEG);

    // Reset in CONVERT cycle 5 of 999 with 77 pending: everything discarded.
    valid_cycles.delete();
    strobe(10'd999, 16'h0999, 1'b0);
    strobe(10'd77, 16'h0077, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_bcd_out", 32'(bcd_out), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(an), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_valid", 32'(valid_cycles.size()), 32'd0);
    check("abort_bcd_held", 32'(bcd_out), 32'h0);
    check("abort_busy_after", 32'(busy), 32'd0);
    strobe(10'd5, 16'h0005, 1'b1);
    repeat (13) @(negedge clk);
    check("post_abort_bcd", 32'(bcd_out), 32'h0005);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
